// File: rtl/code_lock_fsm.sv
// Code lock state machine: parametrised code width, failed-attempt counter, timed lockout.
// Optional auto-relock of OPENED is enabled by defining CODE_LOCK_AUTO_RELOCK_EN.
module code_lock_fsm #(
    parameter int              CODE_W       = 7,
    parameter int              MAX_TRIES    = 3,
    parameter int              LOCKOUT_CYC  = 1000,
    parameter int              OPEN_CYC     = 500,
    parameter logic [CODE_W-1:0] DEFAULT_CODE = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [CODE_W-1:0] code_in,
    input  logic              enter_btn,
    input  logic              set_btn,
    output logic [2:0]        state_o,
    output logic              unlocked_o,
    output logic              alarm_o,
    output logic              lockout_o,
    output logic [3:0]        fail_cnt_o
);

    localparam int MAX_CYC = (LOCKOUT_CYC > OPEN_CYC) ? LOCKOUT_CYC : OPEN_CYC;
    localparam int TW      = $clog2(MAX_CYC + 1);

    localparam logic [TW-1:0] LOCK_LOAD = TW'(LOCKOUT_CYC - 1);
    localparam logic [TW-1:0] OPEN_LOAD = TW'(OPEN_CYC - 1);
    localparam logic [3:0]    TRIES_LIM = 4'(MAX_TRIES);

    typedef enum logic [2:0] {
        IDLE         = 3'b000,
        SET_AWAITING = 3'b001,
        OPENED       = 3'b010,
        ALARM        = 3'b011,
        ENTRY        = 3'b100,
        LOCKOUT      = 3'b101
    } state_t;

    // Bit 0 is enter, bit 1 is set.
    logic [1:0] btn_raw;
    logic [1:0] sync1_reg;
    logic [1:0] sync2_reg;
    logic [1:0] prev_reg;
    logic [1:0] pulse;
    logic       enter_pulse;
    logic       set_pulse;

    state_t            state_reg,  state_next;
    logic [CODE_W-1:0] code_reg,   code_next;
    logic [3:0]        fail_reg,   fail_next;
    logic [TW-1:0]     timer_reg,  timer_next;
    logic [3:0]        fail_inc;

    assign btn_raw = {set_btn, enter_btn};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_reg <= '0;
            sync2_reg <= '0;
            prev_reg  <= '0;
        end else begin
            sync1_reg <= btn_raw;
            sync2_reg <= sync1_reg;
            prev_reg  <= sync2_reg;
        end
    end

    assign pulse       = sync2_reg & ~prev_reg;
    assign enter_pulse = pulse[0];
    assign set_pulse   = pulse[1];

    assign fail_inc = (fail_reg == 4'hF) ? 4'hF : fail_reg + 4'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            code_reg  <= DEFAULT_CODE;
            fail_reg  <= '0;
            timer_reg <= '0;
        end else begin
            state_reg <= state_next;
            code_reg  <= code_next;
            fail_reg  <= fail_next;
            timer_reg <= timer_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        code_next  = code_reg;
        fail_next  = fail_reg;
        timer_next = timer_reg;

        case (state_reg)
            IDLE: begin
                if (enter_pulse) state_next = ENTRY;
            end

            ENTRY: begin
                if (enter_pulse) begin
                    if (code_in == code_reg) begin
                        state_next = OPENED;
                        fail_next  = '0;
                        timer_next = OPEN_LOAD;
                    end else begin
                        fail_next = fail_inc;
                        if (fail_inc == TRIES_LIM) begin
                            state_next = LOCKOUT;
                            timer_next = LOCK_LOAD;
                        end else begin
                            state_next = ALARM;
                        end
                    end
                end
            end

            OPENED: begin
                // Enter wins over set; a pulse also wins over relock expiry.
                if (enter_pulse) begin
                    state_next = IDLE;
                end else if (set_pulse) begin
                    state_next = SET_AWAITING;
`ifdef CODE_LOCK_AUTO_RELOCK_EN
                end else if (timer_reg == '0) begin
                    state_next = IDLE;
                end else begin
                    timer_next = timer_reg - 1'b1;
`endif
                end
            end

            SET_AWAITING: begin
                if (enter_pulse) begin
                    state_next = IDLE;
                end else if (set_pulse) begin
                    code_next  = code_in;
                    state_next = IDLE;
                end
            end

            ALARM: begin
                if (enter_pulse) state_next = IDLE;
            end

            LOCKOUT: begin
                if (timer_reg == '0) begin
                    state_next = IDLE;
                    fail_next  = '0;
                end else begin
                    timer_next = timer_reg - 1'b1;
                end
            end

            default: state_next = IDLE;
        endcase
    end

    assign state_o    = state_reg;
    assign unlocked_o = (state_reg == OPENED);
    assign alarm_o    = (state_reg == ALARM) || (state_reg == LOCKOUT);
    assign lockout_o  = (state_reg == LOCKOUT);
    assign fail_cnt_o = fail_reg;

endmodule

// File: tb/tb_code_lock_fsm.sv
// Directed-vector bench for code_lock_fsm (CODE_W=7, MAX_TRIES=3, LOCKOUT_CYC=20, OPEN_CYC=10).
module tb_code_lock_fsm;

    localparam logic [2:0] S_IDLE  = 3'b000;
    localparam logic [2:0] S_SET   = 3'b001;
    localparam logic [2:0] S_OPEN  = 3'b010;
    localparam logic [2:0] S_ALARM = 3'b011;
    localparam logic [2:0] S_ENTRY = 3'b100;
    localparam logic [2:0] S_LOCK  = 3'b101;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] code_in;
    logic       enter_btn;
    logic       set_btn;
    logic [2:0] state_o;
    logic       unlocked_o;
    logic       alarm_o;
    logic       lockout_o;
    logic [3:0] fail_cnt_o;

    int         n_checks = 0;
    int         n_pass   = 0;
    logic [2:0] exp_state;

    code_lock_fsm #(
        .CODE_W      (7),
        .MAX_TRIES   (3),
        .LOCKOUT_CYC (20),
        .OPEN_CYC    (10),
        .DEFAULT_CODE(7'h2A)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .code_in   (code_in),
        .enter_btn (enter_btn),
        .set_btn   (set_btn),
        .state_o   (state_o),
        .unlocked_o(unlocked_o),
        .alarm_o   (alarm_o),
        .lockout_o (lockout_o),
        .fail_cnt_o(fail_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Press at a negedge; the state must hold after the second edge and move after the third.
    task automatic press(input logic e, input logic s, input logic [6:0] code,
                         input logic [2:0] nxt, input string tag);
        repeat (2) @(negedge clk);
        code_in   = code;
        enter_btn = e;
        set_btn   = s;
        @(posedge clk);
        @(posedge clk);
        #1 check({tag, "_hold"}, state_o, exp_state);
        @(posedge clk);
        #1 check(tag, state_o, nxt);
        $display("press e=%0d s=%0d code=%02h -> state %03b", e, s, code, state_o);
        exp_state = nxt;
        @(negedge clk);
        enter_btn = 1'b0;
        set_btn   = 1'b0;
    endtask

    task automatic attempt(input logic [6:0] code, input logic [2:0] nxt, input string tag);
        press(1'b1, 1'b0, code, S_ENTRY, {tag, "_entry"});
        press(1'b1, 1'b0, code, nxt, tag);
    endtask

    initial begin
        rst_n     = 1'b0;
        code_in   = '0;
        enter_btn = 1'b0;
        set_btn   = 1'b0;
        exp_state = S_IDLE;

        repeat (3) @(posedge clk);
        #1;
        check("rst_state",    state_o,    S_IDLE);
        check("rst_unlocked", unlocked_o, 1'b0);
        check("rst_alarm",    alarm_o,    1'b0);
        check("rst_lockout",  lockout_o,  1'b0);
        check("rst_fail",     fail_cnt_o, 4'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Default code opens
        attempt(7'h2A, S_OPEN, "open_default");
        check("open_unlocked", unlocked_o, 1'b1);
        check("open_fail",     fail_cnt_o, 4'd0);

        // Change code to 15, old code now fails, new code opens
        press(1'b0, 1'b1, 7'h00, S_SET,  "set_arm");
        press(1'b0, 1'b1, 7'h15, S_IDLE, "set_store");
        attempt(7'h2A, S_ALARM, "old_code");
        check("old_code_fail",  fail_cnt_o, 4'd1);
        check("old_code_alarm", alarm_o,    1'b1);
        press(1'b1, 1'b0, 7'h00, S_IDLE, "alarm_clear");
        check("alarm_keep_fail", fail_cnt_o, 4'd1);
        attempt(7'h15, S_OPEN, "new_code");
        check("new_code_fail", fail_cnt_o, 4'd0);
        press(1'b1, 1'b0, 7'h00, S_IDLE, "close");

        // Three wrong codes -> lockout
        attempt(7'h00, S_ALARM, "wrong1");
        check("wrong1_fail", fail_cnt_o, 4'd1);
        press(1'b1, 1'b0, 7'h00, S_IDLE, "wrong1_clr");
        attempt(7'h00, S_ALARM, "wrong2");
        check("wrong2_fail", fail_cnt_o, 4'd2);
        press(1'b1, 1'b0, 7'h00, S_IDLE, "wrong2_clr");
        attempt(7'h00, S_LOCK, "wrong3");
        check("lock_alarm",   alarm_o,    1'b1);
        check("lock_lockout", lockout_o,  1'b1);
        check("lock_fail",    fail_cnt_o, 4'd3);

        // Lockout lasts exactly 20 cycles, ignoring presses
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (k < 20) check($sformatf("lock_cyc%0d", k), state_o, S_LOCK);
            else        check("lock_expire", state_o, S_IDLE);
            if (k == 2)  begin enter_btn = 1'b1; code_in = 7'h15; end
            if (k == 6)  enter_btn = 1'b0;
            if (k == 9)  set_btn = 1'b1;
            if (k == 12) set_btn = 1'b0;
        end
        check("lock_expire_fail", fail_cnt_o, 4'd0);
        $display("lockout expired after 20 cycles, state %03b", state_o);
        exp_state = S_IDLE;

        // Simultaneous enter+set in OPENED: enter wins, code unchanged
        attempt(7'h15, S_OPEN, "reopen");
        press(1'b1, 1'b1, 7'h33, S_IDLE, "both_btn");

        // Holding enter produces one pulse only
        repeat (2) @(negedge clk);
        code_in   = 7'h00;
        enter_btn = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 check("hold_pre", state_o, S_IDLE);
        @(posedge clk);
        #1 check("hold_entry", state_o, S_ENTRY);
        repeat (47) @(posedge clk);
        #1 check("hold_50", state_o, S_ENTRY);
        check("hold_fail", fail_cnt_o, 4'd0);
        $display("held enter 50 cycles, state %03b", state_o);
        @(negedge clk);
        enter_btn = 1'b0;
        exp_state = S_ENTRY;
        press(1'b1, 1'b0, 7'h15, S_OPEN, "code_kept");

`ifdef CODE_LOCK_AUTO_RELOCK_EN
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk);
            #1;
            if (k < 10) check($sformatf("relock_cyc%0d", k), state_o, S_OPEN);
            else        check("relock_expire", state_o, S_IDLE);
        end
        $display("auto relock after 10 cycles, state %03b", state_o);
        exp_state = S_IDLE;
`else
        repeat (100) @(posedge clk);
        #1 check("open_held", state_o, S_OPEN);
        $display("opened held 100 cycles, state %03b", state_o);
        press(1'b1, 1'b0, 7'h00, S_IDLE, "open_close");
`endif

        // Reset mid-lockout
        attempt(7'h00, S_ALARM, "r_wrong1");
        press(1'b1, 1'b0, 7'h00, S_IDLE, "r_clr1");
        attempt(7'h00, S_ALARM, "r_wrong2");
        press(1'b1, 1'b0, 7'h00, S_IDLE, "r_clr2");
        attempt(7'h00, S_LOCK, "r_wrong3");
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_state",    state_o,    S_IDLE);
        check("arst_unlocked", unlocked_o, 1'b0);
        check("arst_alarm",    alarm_o,    1'b0);
        check("arst_lockout",  lockout_o,  1'b0);
        check("arst_fail",     fail_cnt_o, 4'd0);
        $display("async reset mid-lockout, state %03b", state_o);
        @(negedge clk);
        rst_n     = 1'b1;
        exp_state = S_IDLE;
        attempt(7'h2A, S_OPEN, "post_rst_open");
        check("post_rst_unlocked", unlocked_o, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
